// File: rtl/red_pkg.sv
// Shared types and the bitwise combine operator for the stream reduction unit.
package red_pkg;

    typedef enum logic [1:0] {
        RED_AND  = 2'b00,
        RED_OR   = 2'b01,
        RED_XOR  = 2'b10,
        RED_NAND = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    // NAND combines as AND; the inversion is applied once at the output.
    function automatic logic red_op(mode_t m, logic a, logic b);
        case (m)
            RED_OR:  return a | b;
            RED_XOR: return a ^ b;
            default: return a & b;
        endcase
    endfunction

endpackage

// File: rtl/red_word.sv
// Combinational full-word and per-slice reduction of a single input word.
module red_word
    import red_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SLICES = 2
) (
    input  mode_t             mode,
    input  logic [WIDTH-1:0]  word,
    output logic              full,
    output logic [SLICES-1:0] slice
);

    localparam int SW = WIDTH / SLICES;

    always_comb begin
        full  = word[0];
        slice = '0;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            full = red_op(mode, full, word[i]);
        end
        for (int unsigned s = 0; s < SLICES; s++) begin
            slice[s] = word[s*SW];
            for (int unsigned b = 1; b < SW; b++) begin
                slice[s] = red_op(mode, slice[s], word[s*SW+b]);
            end
        end
    end

endmodule

// File: rtl/stream_reduce_unit.sv
// Framed valid/ready stream reducer: one registered full-word and per-slice result per frame.
module stream_reduce_unit
    import red_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SLICES = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_last,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_full,
    output logic [SLICES-1:0] out_slice,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t            state;
    mode_t             mode_q;
    mode_t             cur_mode;
    logic              acc_full;
    logic [SLICES-1:0] acc_slice;
    logic [CNT_W-1:0]  count;
    logic              ovf;

    logic              w_full;
    logic [SLICES-1:0] w_slice;
    logic              first;
    logic              accept;
    logic              is_nand;
    logic              acc_full_nx;
    logic [SLICES-1:0] acc_slice_nx;
    logic [CNT_W-1:0]  count_nx;
    logic              ovf_nx;

    // Mode is taken live on the first beat and from the latch for the rest of the frame.
    assign first    = (state == S_IDLE);
    assign cur_mode = first ? mode_t'(mode) : mode_q;
    assign accept   = in_valid & in_ready;
    assign is_nand  = (cur_mode == RED_NAND);

    red_word #(
        .WIDTH (WIDTH),
        .SLICES(SLICES)
    ) u_red_word (
        .mode (cur_mode),
        .word (in_data),
        .full (w_full),
        .slice(w_slice)
    );

    always_comb begin
        acc_full_nx  = first ? w_full : red_op(mode_q, acc_full, w_full);
        acc_slice_nx = '0;
        for (int unsigned s = 0; s < SLICES; s++) begin
            acc_slice_nx[s] = first ? w_slice[s] : red_op(mode_q, acc_slice[s], w_slice[s]);
        end
        if (first) begin
            count_nx = CNT_W'(1);
            ovf_nx   = 1'b0;
        end else if (count == '1) begin
            count_nx = count;
            ovf_nx   = 1'b1;
        end else begin
            count_nx = count + 1'b1;
            ovf_nx   = ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mode_q    <= RED_AND;
            acc_full  <= 1'b0;
            acc_slice <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_full  <= 1'b0;
            out_slice <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        mode_q    <= cur_mode;
                        acc_full  <= acc_full_nx;
                        acc_slice <= acc_slice_nx;
                        count     <= count_nx;
                        ovf       <= ovf_nx;
                        if (in_last) begin
                            state     <= S_HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_full  <= acc_full_nx ^ is_nand;
                            out_slice <= acc_slice_nx ^ {SLICES{is_nand}};
                            out_count <= count_nx;
                            out_ovf   <= ovf_nx;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_reduce_unit.sv
// Randomized and directed bench for stream_reduce_unit against a ones-counting reference model.
module tb_stream_reduce_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic [1:0] mode;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, out_full_a, out_ovf_a;
    logic [1:0] out_slice_a;
    logic [7:0] out_count_a;
    logic       in_ready_b, out_valid_b, out_full_b, out_ovf_b;
    logic [1:0] out_slice_b;
    logic [1:0] out_count_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fw[$];
    logic       e_full;
    logic [1:0] e_slice;
    int         e_cnt_a, e_cnt_b;
    logic       e_ovf_a, e_ovf_b;

    stream_reduce_unit #(.WIDTH(8), .SLICES(2), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .mode(mode),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_full(out_full_a),
        .out_slice(out_slice_a), .out_count(out_count_a), .out_ovf(out_ovf_a)
    );

    stream_reduce_unit #(.WIDTH(8), .SLICES(2), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .mode(mode),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_full(out_full_b),
        .out_slice(out_slice_b), .out_count(out_count_b), .out_ovf(out_ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic reduce(input logic [1:0] m, input int ones, input int total);
        case (m)
            2'b00:   return ones == total;
            2'b01:   return ones != 0;
            2'b10:   return (ones % 2) == 1;
            default: return ones != total;
        endcase
    endfunction

    task automatic compute_exp(input logic [1:0] m);
        int ones_all = 0;
        int ones_s[2] = '{0, 0};
        int n = fw.size();
        logic [7:0] w;
        for (int i = 0; i < n; i++) begin
            w = fw[i];
            for (int b = 0; b < 8; b++) begin
                if (w[b]) begin
                    ones_all++;
                    ones_s[b/4]++;
                end
            end
        end
        e_full     = reduce(m, ones_all, 8 * n);
        e_slice[0] = reduce(m, ones_s[0], 4 * n);
        e_slice[1] = reduce(m, ones_s[1], 4 * n);
        e_cnt_a    = (n > 255) ? 255 : n;
        e_ovf_a    = (n > 255);
        e_cnt_b    = (n > 3) ? 3 : n;
        e_ovf_b    = (n > 3);
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic [1:0] m);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        mode     = m;
        while (!in_ready_a) begin
            @(negedge clk);
            waited++;
            if (waited > 50) begin
                check("in_ready_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
        mode     = 2'($urandom);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_valid_a"}, out_valid_a, 1'b1);
        check({tag, "_full_a"},  out_full_a,  e_full);
        check({tag, "_slice_a"}, out_slice_a, e_slice);
        check({tag, "_count_a"}, out_count_a, e_cnt_a);
        check({tag, "_ovf_a"},   out_ovf_a,   e_ovf_a);
        check({tag, "_valid_b"}, out_valid_b, 1'b1);
        check({tag, "_full_b"},  out_full_b,  e_full);
        check({tag, "_slice_b"}, out_slice_b, e_slice);
        check({tag, "_count_b"}, out_count_b, e_cnt_b);
        check({tag, "_ovf_b"},   out_ovf_b,   e_ovf_b);
    endtask

    task automatic finish_frame(input string tag, input logic [1:0] m, input int stall);
        compute_exp(m);
        @(negedge clk);
        check_outputs(tag);
        // Garbage beats offered while the unit is holding must be ignored.
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_stall_in_ready"}, in_ready_a, 1'b0);
            check_outputs({tag, "_stall"});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check({tag, "_post_valid"}, out_valid_a, 1'b0);
        check({tag, "_post_in_ready"}, in_ready_a, 1'b1);
        check({tag, "_post_full_kept"}, out_full_a, e_full);
        check({tag, "_post_count_kept"}, out_count_b, e_cnt_b);
    endtask

    task automatic run_frame(input string tag, input logic [1:0] m, input bit force_later,
                             input logic [1:0] later_m, input int stall, input bit gaps);
        logic [1:0] mi;
        for (int i = 0; i < fw.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
            mi = (i == 0) ? m : (force_later ? later_m : 2'($urandom));
            send_beat(fw[i], i == fw.size() - 1, mi);
        end
        finish_frame(tag, m, stall);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        mode      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready_a, 1'b0);
        check("rst_out_valid", out_valid_a, 1'b0);
        check("rst_outputs_a", {out_full_a, out_slice_a, out_count_a, out_ovf_a}, '0);
        check("rst_outputs_b", {out_full_b, out_slice_b, out_count_b, out_ovf_b}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_in_ready", in_ready_a, 1'b1);

        fw = '{8'hFF};
        run_frame("and1", 2'b00, 1'b0, 2'b00, 0, 1'b0);
        fw = '{8'h00, 8'h10};
        run_frame("or2", 2'b01, 1'b0, 2'b00, 1, 1'b0);
        fw = '{8'h01, 8'h03, 8'h80};
        run_frame("xor3", 2'b10, 1'b1, 2'b00, 0, 1'b0);
        fw = '{8'hFF, 8'hFE};
        run_frame("nand2", 2'b11, 1'b1, 2'b01, 5, 1'b0);
        fw = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_frame("and5_sat", 2'b00, 1'b1, 2'b10, 0, 1'b0);
        fw = '{8'h5A};
        run_frame("ovf_clear", 2'b10, 1'b0, 2'b00, 0, 1'b0);

        // Abort a frame half way with reset; nothing may come out for it.
        send_beat(8'h0F, 1'b0, 2'b01);
        send_beat(8'hF0, 1'b0, 2'b01);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready_a, 1'b0);
        check("midrst_valid", out_valid_a, 1'b0);
        check("midrst_outputs_a", {out_full_a, out_slice_a, out_count_a, out_ovf_a}, '0);
        check("midrst_outputs_b", {out_full_b, out_slice_b, out_count_b, out_ovf_b}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fw = '{8'h01};
        run_frame("after_rst_or", 2'b01, 1'b0, 2'b00, 0, 1'b0);

        for (int f = 0; f < 40; f++) begin
            int len = $urandom_range(1, 6);
            fw.delete();
            for (int i = 0; i < len; i++) begin
                // Bias towards all-ones/all-zeros nibbles so AND/OR results vary.
                case ($urandom_range(0, 3))
                    0: fw.push_back(8'hFF);
                    1: fw.push_back(8'h00);
                    2: fw.push_back({4'hF, 4'($urandom)});
                    default: fw.push_back(8'($urandom));
                endcase
            end
            run_frame("rand", 2'($urandom), 1'b0, 2'b00, $urandom_range(0, 3), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
